// File: rtl/pe_pkg.sv
// Shared defaults and drain FSM encoding for the processing-element array datapath.
package pe_pkg;

    localparam int unsigned ARRAY_DIM_DEF = 16;
    localparam int unsigned ACC_WIDTH_DEF = 32;
    localparam int unsigned OUT_WIDTH_DEF = 8;
    localparam int unsigned DEPTH_DEF     = 1024;
    localparam int unsigned SHIFT_W       = 5;

    typedef enum logic [1:0] {
        DRAIN_IDLE = 2'd0,
        DRAIN_RUN  = 2'd1,
        DRAIN_DONE = 2'd2
    } drain_state_e;

endpackage

// File: rtl/psum_bank_buffer_if.sv
// Accumulate request port and drained-word stream of psum_bank_buffer.
interface psum_bank_buffer_if
    import pe_pkg::*;
#(
    parameter int unsigned ARRAY_DIM = ARRAY_DIM_DEF,
    parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    localparam int unsigned AW       = $clog2(DEPTH)
);

    logic                           acc_enable;
    logic                           acc_clear;
    logic [AW-1:0]                  acc_addr;
    logic [ARRAY_DIM*ACC_WIDTH-1:0] psum_in;
    logic                           out_valid;
    logic                           out_ready;
    logic [ARRAY_DIM*OUT_WIDTH-1:0] out_data;
    logic                           out_last;

    modport master (
        output acc_enable, acc_clear, acc_addr, psum_in, out_ready,
        input  out_valid, out_data, out_last
    );

    modport slave (
        input  acc_enable, acc_clear, acc_addr, psum_in, out_ready,
        output out_valid, out_data, out_last
    );

endinterface

// File: rtl/psum_requant.sv
// One channel of drain requantisation: optional ReLU, arithmetic right shift, saturate.
// PSUM_BANK_BUFFER_RELU_EN: clamp negative accumulators to zero before shifting.
module psum_requant
    import pe_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF
) (
    input  logic signed [ACC_WIDTH-1:0] acc,
    input  logic        [SHIFT_W-1:0]   shift,
    output logic        [OUT_WIDTH-1:0] sat_c
);

    localparam logic signed [ACC_WIDTH-1:0] MAX_V =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] MIN_V =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] relu;
    logic signed [ACC_WIDTH-1:0] shifted;

    always_comb begin
        relu = acc;
`ifdef PSUM_BANK_BUFFER_RELU_EN
        if (acc[ACC_WIDTH-1]) begin
            relu = '0;
        end
`else
`endif
        shifted = relu >>> shift;
        sat_c   = shifted[OUT_WIDTH-1:0];
        if (shifted > MAX_V) begin
            sat_c = MAX_V[OUT_WIDTH-1:0];
        end else if (shifted < MIN_V) begin
            sat_c = MIN_V[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/psum_bank_buffer.sv
// Double-banked partial-sum buffer: pipelined accumulate into one bank, requantised drain of the other.
// PSUM_BANK_BUFFER_RELU_EN (in psum_requant) enables ReLU on drained channels.
module psum_bank_buffer
    import pe_pkg::*;
#(
    parameter int unsigned ARRAY_DIM = ARRAY_DIM_DEF,
    parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int unsigned OUT_WIDTH = OUT_WIDTH_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    psum_bank_buffer_if.slave  bus,
    input  logic               bank_swap,
    input  logic               drain_start,
    input  logic [AW-1:0]      drain_base,
    input  logic [AW:0]        drain_len,
    input  logic [SHIFT_W-1:0] shift,
    output logic               busy,
    output logic               done,
    output logic               swap_err
);

    localparam int unsigned WORD_W = ARRAY_DIM * ACC_WIDTH;

    drain_state_e state, state_nxt;
    logic swap_ok, out_load, out_pop;
    logic bank_sel, bank_sel_nxt;

    logic [WORD_W-1:0] mem [2][DEPTH];
    logic [WORD_W-1:0] acc_rdata, operand, sum_c, drain_word;

    logic              s1_valid, s1_clear, s1_bank;
    logic [AW-1:0]     s1_addr;
    logic [WORD_W-1:0] s1_psum;
    logic              wb_valid, wb_bank;
    logic [AW-1:0]     wb_addr;
    logic [WORD_W-1:0] wb_sum;

    logic [AW-1:0]                  rd_addr, rd_addr_inc;
    logic [AW:0]                    issue_left;
    logic [SHIFT_W-1:0]             shift_q;
    logic [ARRAY_DIM*OUT_WIDTH-1:0] req_data;

    assign bank_sel_nxt = bank_sel ^ swap_ok;
    assign out_pop      = bus.out_valid && bus.out_ready;
    assign rd_addr_inc  = (rd_addr == AW'(DEPTH - 1)) ? '0 : rd_addr + 1'b1;
    assign drain_word   = mem[~bank_sel][rd_addr];

    // Stage 1 adds onto the word written last cycle when it targets the same location.
    always_comb begin
        operand = acc_rdata;
        if (wb_valid && (wb_addr == s1_addr) && (wb_bank == s1_bank)) begin
            operand = wb_sum;
        end
        sum_c = '0;
        for (int unsigned c = 0; c < ARRAY_DIM; c++) begin
            sum_c[c*ACC_WIDTH +: ACC_WIDTH] = s1_clear ? s1_psum[c*ACC_WIDTH +: ACC_WIDTH]
                : operand[c*ACC_WIDTH +: ACC_WIDTH] + s1_psum[c*ACC_WIDTH +: ACC_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (s1_valid) begin
            mem[s1_bank][s1_addr] <= sum_c;
        end
        if (bus.acc_enable) begin
            acc_rdata <= mem[bank_sel_nxt][bus.acc_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_clear <= 1'b0;
            s1_bank  <= 1'b0;
            s1_addr  <= '0;
            s1_psum  <= '0;
            wb_valid <= 1'b0;
            wb_bank  <= 1'b0;
            wb_addr  <= '0;
            wb_sum   <= '0;
        end else begin
            s1_valid <= bus.acc_enable;
            if (bus.acc_enable) begin
                s1_clear <= bus.acc_clear;
                s1_bank  <= bank_sel_nxt;
                s1_addr  <= bus.acc_addr;
                s1_psum  <= bus.psum_in;
            end
            wb_valid <= s1_valid;
            if (s1_valid) begin
                wb_bank <= s1_bank;
                wb_addr <= s1_addr;
                wb_sum  <= sum_c;
            end
        end
    end

    for (genvar c = 0; c < ARRAY_DIM; c++) begin : g_ch
        psum_requant #(
            .ACC_WIDTH (ACC_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_requant (
            .acc   (drain_word[c*ACC_WIDTH +: ACC_WIDTH]),
            .shift (shift_q),
            .sat_c (req_data[c*OUT_WIDTH +: OUT_WIDTH])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DRAIN_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Swaps only land with the drain idle and no accumulate in flight.
    always_comb begin
        state_nxt = state;
        swap_ok   = 1'b0;
        out_load  = 1'b0;
        case (state)
            DRAIN_IDLE: begin
                swap_ok = bank_swap && !s1_valid;
                if (drain_start) begin
                    state_nxt = (drain_len == '0) ? DRAIN_DONE : DRAIN_RUN;
                end
            end
            DRAIN_RUN: begin
                out_load = (issue_left != '0) && (!bus.out_valid || bus.out_ready);
                if (out_pop && bus.out_last) begin
                    state_nxt = DRAIN_DONE;
                end
            end
            DRAIN_DONE: state_nxt = DRAIN_IDLE;
            default:    state_nxt = DRAIN_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_sel      <= 1'b0;
            swap_err      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            rd_addr       <= '0;
            issue_left    <= '0;
            shift_q       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_data  <= '0;
        end else begin
            bank_sel <= bank_sel_nxt;
            swap_err <= bank_swap && !swap_ok;
            busy     <= (state_nxt == DRAIN_RUN);
            done     <= (state_nxt == DRAIN_DONE);
            if ((state == DRAIN_IDLE) && drain_start) begin
                rd_addr    <= drain_base;
                issue_left <= drain_len;
                shift_q    <= shift;
            end else if (out_load) begin
                rd_addr    <= rd_addr_inc;
                issue_left <= issue_left - 1'b1;
            end
            if (out_load) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= req_data;
                bus.out_last  <= (issue_left == (AW+1)'(1));
            end else if (out_pop) begin
                bus.out_valid <= 1'b0;
                bus.out_last  <= 1'b0;
            end
        end
    end

endmodule
